// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide/remainder unit.
package div_pkg;

  // Operation encoding, matching divsel[1:0]
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } divop_t;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // divsel bit that carries the request strobe
  localparam int DIV_REQ_BIT = 2;

  // Constants for the default 32-bit configuration
  localparam int                   DIV_WIDTH    = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = '1;
  localparam logic [DIV_WIDTH-1:0] DIV_SMIN     = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  // DIV and REM treat operands as two's complement
  function automatic logic op_is_signed(input divop_t op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder rather than the quotient
  function automatic logic op_is_rem(input divop_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits and record the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // The shifted remainder can exceed WIDTH bits, so compare and subtract one bit wider
  logic [WIDTH:0] shifted;
  logic           fits;

  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, divisor});

  // The difference is always below the divisor, so it fits back into WIDTH bits
  always_comb begin
    rem_out = shifted[WIDTH-1:0];
    if (fits) begin
      rem_out = WIDTH'(shifted - {1'b0, divisor});
    end
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit for the Execute stage.
// Magnitudes are divided with a restoring algorithm over WIDTH cycles and the
// signs are restored when the result is registered. Divide-by-zero and signed
// overflow bypass the iteration and finish one cycle after launch.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       divsel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hold,
  input  logic             kill,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] res
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q;
  divop_t           op_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             busy_q;
  logic             ready_q;

  divop_t           req_op;
  logic             req_signed;
  logic             req_rem;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] special_res;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] res_d;

  // Decode the incoming request: operand magnitudes and the early-exit cases
  always_comb begin
    req_op      = divop_t'(divsel[1:0]);
    req_signed  = op_is_signed(req_op);
    req_rem     = op_is_rem(req_op);
    a_neg       = req_signed & a[WIDTH-1];
    b_neg       = req_signed & b[WIDTH-1];
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    b_zero      = (b == '0);
    ovf         = req_signed && (a == SMIN) && (b == ALL_ONES);
    special_res = '0;
    if (b_zero) begin
      special_res = req_rem ? a : ALL_ONES;
    end else if (!req_rem) begin
      special_res = a;
    end
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(divisor_q),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  // Sign fix-up on the final iteration: quotient negative when operand signs
  // differ, remainder follows the dividend
  always_comb begin
    quo_fix = neg_quo_q ? -step_quo : step_quo;
    rem_fix = neg_rem_q ? -step_rem : step_rem;
    res_d   = op_is_rem(op_q) ? rem_fix : quo_fix;
  end

  // Control FSM with the iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (divsel[DIV_REQ_BIT] && !kill) begin
            op_q      <= req_op;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            rem_q     <= '0;
            quo_q     <= a_mag;
            divisor_q <= b_mag;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (b_zero || ovf) begin
              res_q   <= special_res;
              ready_q <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              res_q   <= res_d;
              ready_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // kill wins over hold; hold keeps the result presented
          if (kill || !hold) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign res   = res_q;

endmodule
